udt_rx_hdr_parse: RTL and testbench
===================================

Name: udt_rx_hdr_parse

Overview:
Receive-side UDT header parser. It sits between the UDP-stripped 64-bit receive stream from the 10G path and the UDT packet decoder.
- Splits each UDT packet into a registered header sideband and a payload stream.
- Filters packets by destination socket ID.
- Drops runt packets and counts accepted and dropped packets.

Parameters:
DW, 64, stream data width in bits (fixed at 64; header = 2 beats)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
local_sock_id  in  32  socket ID accepted by this parser
s_data  in  64  input beat; byte 0 in [63:56] (network order)
s_keep  in  8  byte enables; bit 7 = byte 0; contiguous from MSB
s_valid  in  1  input beat valid
s_last  in  1  last beat of packet
s_ready  out  1  input ready
hdr_valid  out  1  one-cycle pulse: header fields valid
hdr_is_ctrl  out  1  UDT F bit (1 = control packet)
hdr_seq_or_type  out  31  data: sequence number; control: {type[14:0], reserved[15:0]}
hdr_info  out  32  word1 (data: message number/flags; control: additional info)
hdr_tstamp  out  32  word2 timestamp
hdr_no_payload  out  1  packet ended with the header (exactly 16 bytes)
m_data  out  64  payload beat
m_keep  out  8  payload byte enables
m_valid  out  1  payload valid
m_last  out  1  payload last
m_ready  in  1  downstream ready
pkt_cnt  out  CNT_W  accepted packets, wraps
drop_cnt  out  CNT_W  dropped packets (runt or socket mismatch), wraps

Behaviour:
- Reset (async assert, sync release): state=IDLE. hdr_* = 0, m_valid = 0, m_* = 0, counters = 0. s_ready = 1 after reset.
- A beat transfers on s_valid & s_ready. s_ready = !m_valid | m_ready in PAYLOAD state; it is 1 in all other states.
- The header occupies beat0 and beat1:
  - word0 = beat0[63:32], word1 = beat0[31:0]
  - word2 = beat1[63:32], word3 (destination socket ID) = beat1[31:0]
  - F bit = word0[31].
- FSM states: IDLE (expect beat0), HDR1 (expect beat1), PAYLOAD, DROP.
- IDLE, on beat transfer:
  - s_last=1 or s_keep != 8'hFF: runt. drop_cnt++. Stay IDLE if s_last, else go to DROP.
  - Otherwise: latch word0/word1 into a shadow register and go to HDR1.
- HDR1, on beat transfer:
  - Runt (s_keep != 8'hFF): drop_cnt++. Go to IDLE if s_last, else DROP.
  - Socket mismatch (word3 != local_sock_id): drop_cnt++. Go to IDLE if s_last, else DROP.
  - Otherwise: on the next cycle hdr_valid=1 for exactly one cycle with all hdr_* fields updated; pkt_cnt++. hdr_no_payload = s_last. Go to IDLE if s_last, else PAYLOAD.
- Header fields hold their value until the next accepted header.
- PAYLOAD:
  - Single registered output stage. An accepted input beat loads m_data/m_keep/m_last and sets m_valid.
  - m_valid clears on m_ready when no new beat is loaded.
  - The m_* outputs hold stable while m_valid & !m_ready.
  - The input beat with s_last returns the FSM to IDLE.
  - The first payload beat reaches m_valid no earlier than the hdr_valid cycle, so the header is always delivered before its payload.
- DROP: accept and discard every beat. Go to IDLE on s_last. m_valid is never asserted.
- hdr_valid has no backpressure; the decoder must sample it on the pulse.
- A new packet's beat0 may arrive in IDLE while the last payload beat is still held in m_*. It is accepted; its header pulse occurs no earlier than the first cycle after that last beat leaves (m_valid & m_ready).
- Counters wrap from 2^CNT_W-1 to 0.
- Reset mid-packet: all state is cleared. The next input beat is treated as beat0 of a new packet. Upstream must reset together with this block.

Test Plan:
- Data packet, 4 beats:
  - Stimulus: word0=0x0000_1234, word3=local_sock_id=0x0000_00A5, payload 0x11..11 and 0x22..22 (last, keep=8'hF0).
  - Response: one hdr_valid pulse with hdr_is_ctrl=0, hdr_seq_or_type=0x1234; m_* delivers 2 beats, the last with keep=8'hF0; pkt_cnt=1.
- Control ACK, header-only: word0=0x8002_0000, 2 beats, s_last on beat1 → hdr_is_ctrl=1, type=2, hdr_no_payload=1, no m_valid.
- Socket mismatch: word3=0x0000_00A6 with 3 payload beats → no hdr_valid, no m_valid, drop_cnt=1, next valid packet accepted normally.
- Runt: single beat with s_last and keep=8'hFF, then beat0 with keep=8'hF0 followed by one more beat → drop_cnt=2, FSM back in IDLE, nothing output.
- Backpressure: hold m_ready=0 for 5 cycles mid-payload → s_ready=0 while m_valid is held, m_data stable, no beats lost or duplicated.
- Async reset asserted mid-payload → all outputs 0 immediately; after release, a clean packet parses correctly with pkt_cnt=1.

Source files
------------

// File: rtl/udt_rx_hdr_parse.sv
// Receive-side UDT header parser.
// The first two 64-bit beats of each packet carry the UDT header. This block
// emits them as a one-cycle header sideband pulse and forwards the rest of the
// packet as a payload stream through a single registered output stage.
// Packets addressed to another socket, and runt packets, are discarded and
// counted.
module udt_rx_hdr_parse #(
    parameter int DW    = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      local_sock_id,
    input  logic [DW-1:0]    s_data,
    input  logic [7:0]       s_keep,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             hdr_valid,
    output logic             hdr_is_ctrl,
    output logic [30:0]      hdr_seq_or_type,
    output logic [31:0]      hdr_info,
    output logic [31:0]      hdr_tstamp,
    output logic             hdr_no_payload,
    output logic [DW-1:0]    m_data,
    output logic [7:0]       m_keep,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    // Header bundle: {is_ctrl, seq_or_type[30:0], info[31:0], tstamp[31:0], no_payload}
    localparam int HW = 1 + 31 + 32 + 32 + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR1    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      shadow_q, shadow_d;
    logic               pend_q, pend_d;
    logic [HW-1:0]      pend_hdr_q, pend_hdr_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [HW-1:0]      hdr_q, hdr_d;
    logic [DW-1:0]      m_data_q, m_data_d;
    logic [7:0]         m_keep_q, m_keep_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [1:0]         rst_sync_q;

    logic               rst_int_n;
    logic               m_free;
    logic               s_ready_c;
    logic               beat;
    logic               new_hdr;
    logic [HW-1:0]      new_hdr_bits;

    // Reset synchronizer: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // The output stage can take a new beat when it is empty or draining this cycle.
    assign m_free    = !m_valid_q | m_ready;
    assign s_ready_c = (state_q == ST_PAYLOAD) ? m_free : 1'b1;
    assign beat      = s_valid & s_ready_c;

    // Header fields assembled from the shadowed beat0 and the current beat1.
    assign new_hdr_bits = {shadow_q[63], shadow_q[62:32], shadow_q[31:0],
                           s_data[63:32], s_last};

    // Next-state logic: packet FSM, payload stage, header scheduling, counters.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        pend_hdr_d  = pend_hdr_q;
        hdr_valid_d = 1'b0;
        hdr_d       = hdr_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q & !m_ready;
        pkt_d       = pkt_q;
        drop_d      = drop_q;
        new_hdr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    if (s_last || (s_keep != 8'hFF)) begin
                        drop_d  = drop_q + 1'b1;
                        state_d = s_last ? ST_IDLE : ST_DROP;
                    end else begin
                        shadow_d = s_data;
                        state_d  = ST_HDR1;
                    end
                end
            end
            ST_HDR1: begin
                if (beat) begin
                    if ((s_keep != 8'hFF) || (s_data[31:0] != local_sock_id)) begin
                        drop_d  = drop_q + 1'b1;
                        state_d = s_last ? ST_IDLE : ST_DROP;
                    end else begin
                        new_hdr = 1'b1;
                        pkt_d   = pkt_q + 1'b1;
                        state_d = s_last ? ST_IDLE : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (beat) begin
                    m_data_d  = s_data;
                    m_keep_d  = s_keep;
                    m_last_d  = s_last;
                    m_valid_d = 1'b1;
                    if (s_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A header is released only once the previous packet's last beat has
        // left the output stage; until then it waits in the pending buffer.
        if (pend_q && m_free) begin
            hdr_valid_d = 1'b1;
            hdr_d       = pend_hdr_q;
            pend_d      = 1'b0;
        end
        if (new_hdr) begin
            if (!pend_q && m_free) begin
                hdr_valid_d = 1'b1;
                hdr_d       = new_hdr_bits;
            end else begin
                pend_d     = 1'b1;
                pend_hdr_d = new_hdr_bits;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            pend_q      <= 1'b0;
            pend_hdr_q  <= '0;
            hdr_valid_q <= 1'b0;
            hdr_q       <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            pkt_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_hdr_q  <= pend_hdr_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_q       <= hdr_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            pkt_q       <= pkt_d;
            drop_q      <= drop_d;
        end
    end

    assign s_ready         = s_ready_c;
    assign hdr_valid       = hdr_valid_q;
    assign hdr_is_ctrl     = hdr_q[96];
    assign hdr_seq_or_type = hdr_q[95:65];
    assign hdr_info        = hdr_q[64:33];
    assign hdr_tstamp      = hdr_q[32:1];
    assign hdr_no_payload  = hdr_q[0];
    assign m_data          = m_data_q;
    assign m_keep          = m_keep_q;
    assign m_valid         = m_valid_q;
    assign m_last          = m_last_q;
    assign pkt_cnt         = pkt_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_udt_rx_hdr_parse.sv
// Directed testbench for udt_rx_hdr_parse: table of packets plus hand-written
// backpressure and mid-packet reset sequences.
module tb_udt_rx_hdr_parse;

    localparam logic [31:0] SOCK = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] local_sock_id;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid, s_last, s_ready;
    logic        hdr_valid, hdr_is_ctrl, hdr_no_payload;
    logic [30:0] hdr_seq_or_type;
    logic [31:0] hdr_info, hdr_tstamp;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_valid, m_last, m_ready;
    logic [15:0] pkt_cnt, drop_cnt;

    always #5 clk = ~clk;

    udt_rx_hdr_parse #(.DW(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .local_sock_id(local_sock_id),
        .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .hdr_valid(hdr_valid), .hdr_is_ctrl(hdr_is_ctrl),
        .hdr_seq_or_type(hdr_seq_or_type), .hdr_info(hdr_info),
        .hdr_tstamp(hdr_tstamp), .hdr_no_payload(hdr_no_payload),
        .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        int          nb;
        logic [7:0]  keep0, last_keep;
        logic        e_hdr, e_ctrl;
        logic [30:0] e_seq;
        logic        e_nopay;
        int          e_npay, e_dpkt, e_ddrop;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Monitor state
    int          hdr_seen = 0;
    int          order_err = 0;
    logic        mh_ctrl, mh_nopay;
    logic [30:0] mh_seq;
    logic [31:0] mh_info, mh_tstamp;
    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];

    logic [63:0] held;
    int          wcnt;
    logic [15:0] pkt0, drop0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pay(input int b);
        logic [7:0] x;
        x = 8'((b - 1) * 17);
        return {8{x}};
    endfunction

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (hdr_valid) begin
            hdr_seen++;
            mh_ctrl   = hdr_is_ctrl;
            mh_seq    = hdr_seq_or_type;
            mh_info   = hdr_info;
            mh_tstamp = hdr_tstamp;
            mh_nopay  = hdr_no_payload;
        end
        if (m_valid && m_ready && rst_n) begin
            if (hdr_seen == 0) order_err++;
            q_data.push_back(m_data);
            q_keep.push_back(m_keep);
            q_last.push_back(m_last);
        end
    end

    task automatic clear_mon();
        hdr_seen  = 0;
        order_err = 0;
        q_data.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    // Present one beat and hold it until the handshake completes (bounded).
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit ok;
        int t;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_timeout: s_ready stayed 0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic send_pkt(input vec_t v);
        for (int b = 0; b < v.nb; b++) begin
            logic [63:0] d;
            logic [7:0]  k;
            d = (b == 0) ? {v.w0, v.w1} : (b == 1) ? {v.w2, v.w3} : pay(b);
            k = (b == 0) ? v.keep0 : (b == v.nb - 1) ? v.last_keep : 8'hFF;
            send_beat(d, k, b == v.nb - 1);
        end
    endtask

    task automatic check_pkt(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, "_hdr_pulses"}, 64'(hdr_seen), 64'(v.e_hdr));
        if (v.e_hdr) begin
            chk({p, "_ctrl"},   64'(mh_ctrl),   64'(v.e_ctrl));
            chk({p, "_seq"},    64'(mh_seq),    64'(v.e_seq));
            chk({p, "_info"},   64'(mh_info),   64'(v.w1));
            chk({p, "_tstamp"}, 64'(mh_tstamp), 64'(v.w2));
            chk({p, "_nopay"},  64'(mh_nopay),  64'(v.e_nopay));
        end
        chk({p, "_npay"}, 64'(q_data.size()), 64'(v.e_npay));
        for (int j = 0; j < v.e_npay && j < q_data.size(); j++) begin
            chk($sformatf("%s_data%0d", p, j), q_data[j], pay(j + 2));
            chk($sformatf("%s_keep%0d", p, j), 64'(q_keep[j]),
                64'((j == v.e_npay - 1) ? v.last_keep : 8'hFF));
            chk($sformatf("%s_last%0d", p, j), 64'(q_last[j]), 64'(j == v.e_npay - 1));
        end
        chk({p, "_order"}, 64'(order_err), 64'd0);
        chk({p, "_pkt_cnt"},  64'(pkt_cnt),  64'(pkt0 + 16'(v.e_dpkt)));
        chk({p, "_drop_cnt"}, 64'(drop_cnt), 64'(drop0 + 16'(v.e_ddrop)));
        $display("pkt %0d: hdr=%0d payload=%0d pkt_cnt=%0d drop_cnt=%0d",
                 idx, hdr_seen, q_data.size(), pkt_cnt, drop_cnt);
    endtask

    vec_t vecs[7];
    vec_t bp_v;

    initial begin
        // w0, w1, w2, w3, nb, keep0, last_keep, e_hdr, e_ctrl, e_seq, e_nopay, e_npay, e_dpkt, e_ddrop
        vecs[0] = '{32'h0000_1234, 32'h4000_0001, 32'h0000_0100, SOCK, 4, 8'hFF, 8'hF0,
                    1, 0, 31'h0000_1234, 0, 2, 1, 0};
        vecs[1] = '{32'h8002_0000, 32'h0000_0000, 32'h0000_0200, SOCK, 2, 8'hFF, 8'hFF,
                    1, 1, 31'h0002_0000, 1, 0, 1, 0};
        vecs[2] = '{32'h0000_0055, 32'h0000_0000, 32'h0000_0300, 32'h0000_00A6, 5, 8'hFF, 8'hFF,
                    0, 0, 31'h0, 0, 0, 0, 1};
        vecs[3] = '{32'h0000_0007, 32'h2000_0003, 32'h0000_0400, SOCK, 3, 8'hFF, 8'hFF,
                    1, 0, 31'h0000_0007, 0, 1, 1, 0};
        vecs[4] = '{32'h0000_0009, 32'h0000_0000, 32'h0, 32'h0, 1, 8'hFF, 8'hFF,
                    0, 0, 31'h0, 0, 0, 0, 1};
        vecs[5] = '{32'h0000_000A, 32'h0000_0000, 32'h0, SOCK, 2, 8'hF0, 8'hFF,
                    0, 0, 31'h0, 0, 0, 0, 1};
        vecs[6] = '{32'h0000_000B, 32'h0000_0000, 32'h0, SOCK, 2, 8'hFF, 8'hFC,
                    0, 0, 31'h0, 0, 0, 0, 1};
        bp_v    = '{32'h0000_00BB, 32'h1000_0000, 32'h0000_0500, SOCK, 6, 8'hFF, 8'hFF,
                    1, 0, 31'h0000_00BB, 0, 4, 1, 0};

        local_sock_id = SOCK;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst_hdr_seq",   64'(hdr_seq_or_type), 64'd0);
        chk("rst_m_valid",   64'(m_valid), 64'd0);
        chk("rst_m_data",    m_data, 64'd0);
        chk("rst_pkt_cnt",   64'(pkt_cnt), 64'd0);
        chk("rst_drop_cnt",  64'(drop_cnt), 64'd0);
        chk("rst_s_ready",   64'(s_ready), 64'd1);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Table-driven packets
        for (int i = 0; i < 7; i++) begin
            pkt0  = pkt_cnt;
            drop0 = drop_cnt;
            clear_mon();
            send_pkt(vecs[i]);
            repeat (5) @(negedge clk);
            check_pkt(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // Backpressure: stall m_ready for 5 cycles mid-payload
        pkt0  = pkt_cnt;
        drop0 = drop_cnt;
        clear_mon();
        fork
            send_pkt(bp_v);
            begin
                wcnt = 0;
                while (!m_valid && wcnt < 100) begin
                    @(negedge clk);
                    wcnt++;
                end
                chk("bp_m_valid_seen", 64'(m_valid), 64'd1);
                @(posedge clk);
                #1 m_ready = 1'b0;
                @(negedge clk);
                held = m_data;
                for (int c = 0; c < 5; c++) begin
                    chk($sformatf("bp_s_ready%0d", c), 64'(s_ready), 64'd0);
                    chk($sformatf("bp_m_valid%0d", c), 64'(m_valid), 64'd1);
                    chk($sformatf("bp_m_data%0d", c), m_data, held);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check_pkt(7, bp_v);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a payload
        clear_mon();
        send_beat({vecs[0].w0, vecs[0].w1}, 8'hFF, 1'b0);
        send_beat({vecs[0].w2, vecs[0].w3}, 8'hFF, 1'b0);
        send_beat(pay(2), 8'hFF, 1'b0);
        s_data  = pay(3);
        s_keep  = 8'hFF;
        s_last  = 1'b0;
        s_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_m_valid",   64'(m_valid), 64'd0);
        chk("arst_m_data",    m_data, 64'd0);
        chk("arst_hdr_valid", 64'(hdr_valid), 64'd0);
        chk("arst_hdr_seq",   64'(hdr_seq_or_type), 64'd0);
        chk("arst_pkt_cnt",   64'(pkt_cnt), 64'd0);
        chk("arst_drop_cnt",  64'(drop_cnt), 64'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pkt0  = 16'd0;
        drop0 = 16'd0;
        clear_mon();
        send_pkt(vecs[3]);
        repeat (5) @(negedge clk);
        check_pkt(8, vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
